// File: rtl/matmul_tiled_engine_pkg.sv
// Shared types and helpers for the tiled signed matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Counter width for an index that ranges over 0..n-1 (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Row-major flat position of element [r][c] in a matrix with `cols` columns.
  function automatic int flat_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  // Arithmetic right shift followed by a clip to a signed `ow`-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input int sh, input int ow);
    logic signed [63:0] s, hi, lo;
    s  = v >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

  // True when sat_shift would have clipped the value.
  function automatic logic sat_hit(input logic signed [63:0] v,
                                   input int sh, input int ow);
    logic signed [63:0] s, hi, lo;
    s  = v >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) || (s < lo);
  endfunction

endpackage

// File: rtl/matmul_tiled_engine_if.sv
// Command/operand/result bundle between a controller and the matmul engine.
interface matmul_tiled_engine_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int M_DIM       = 2,
  parameter int K_DIM       = 3,
  parameter int N_DIM       = 2,
  parameter int SHIFT_W     = 5
);
  logic                                op_start_mm;
  logic                                acc_mode;
  logic [SHIFT_W-1:0]                  shift_amt;
  logic [M_DIM*K_DIM*DATA_WIDTH-1:0]   matrix_a_flat;
  logic [K_DIM*N_DIM*DATA_WIDTH-1:0]   matrix_b_flat;
  logic [M_DIM*N_DIM*ACCUM_WIDTH-1:0]  output_matrix_c_flat;
  logic [M_DIM*N_DIM*OUT_WIDTH-1:0]    output_q_flat;
  logic                                op_busy_mm;
  logic                                op_done_mm;
  logic                                overflow_flag;

  modport master (
    output op_start_mm, acc_mode, shift_amt, matrix_a_flat, matrix_b_flat,
    input  output_matrix_c_flat, output_q_flat, op_busy_mm, op_done_mm, overflow_flag
  );

  modport slave (
    input  op_start_mm, acc_mode, shift_amt, matrix_a_flat, matrix_b_flat,
    output output_matrix_c_flat, output_q_flat, op_busy_mm, op_done_mm, overflow_flag
  );
endinterface

// File: rtl/matmul_tiled_engine_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
module matmul_mac_lane #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  a,
  input  logic signed [DATA_WIDTH-1:0]  b,
  output logic signed [ACCUM_WIDTH-1:0] acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;

  // Accumulator: clear wins over enable; the sum wraps at ACCUM_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACCUM_WIDTH'(prod);
  end

endmodule

// File: rtl/matmul_tiled_engine.sv
// Tiled signed matrix multiply C = A*B (or C += A*B) with a requantised output.
//
// state | meaning
// IDLE  | waiting for op_start_mm; operands latched on start
// LOAD  | clear lane accumulators, reset tile indices
// MAC   | K_DIM cycles of multiply-accumulate for the current tile
// WRITE | commit lane results to C/q, advance tile
// DONE  | one-cycle completion pulse
module matmul_tiled_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int M_DIM       = 2,
  parameter int K_DIM       = 3,
  parameter int N_DIM       = 2,
  parameter int LANES       = 1,
  parameter int SHIFT_W     = 5
) (
  input logic                clk,
  input logic                rst_n,
  matmul_tiled_engine_if.slave bus
);

  localparam int NG  = N_DIM / LANES;
  localparam int MW  = idx_w(M_DIM);
  localparam int KW  = idx_w(K_DIM);
  localparam int NGW = idx_w(NG);
  localparam int CW  = idx_w(M_DIM * N_DIM);

  if (N_DIM % LANES != 0) begin : g_bad_lanes
    $error("matmul_tiled_engine: N_DIM must be a multiple of LANES");
  end

  state_t state_q, state_d;

  logic [MW-1:0]  m_q;
  logic [NGW-1:0] ng_q;
  logic [KW-1:0]  k_q;

  logic [M_DIM*K_DIM*DATA_WIDTH-1:0] a_lat;
  logic [K_DIM*N_DIM*DATA_WIDTH-1:0] b_lat;
  logic                              acc_mode_q;
  logic [SHIFT_W-1:0]                shift_q;
  logic                              ovf_q;

  logic signed [ACCUM_WIDTH-1:0] c_reg [M_DIM*N_DIM];
  logic        [OUT_WIDTH-1:0]   q_reg [M_DIM*N_DIM];

  logic lane_clr, lane_en, wr_en;
  logic last_k, last_ng, last_m, last_tile;

  logic signed [DATA_WIDTH-1:0]  a_el;
  logic        [CW-1:0]          wr_idx [LANES];
  logic signed [ACCUM_WIDTH-1:0] c_new  [LANES];
  logic        [OUT_WIDTH-1:0]   q_new  [LANES];
  logic        [LANES-1:0]       lane_sat;

  assign last_k    = (k_q == KW'(K_DIM - 1));
  assign last_ng   = (ng_q == NGW'(NG - 1));
  assign last_m    = (m_q == MW'(M_DIM - 1));
  assign last_tile = last_ng && last_m;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and lane control decode.
  always_comb begin
    state_d  = state_q;
    lane_clr = 1'b0;
    lane_en  = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.op_start_mm) state_d = ST_LOAD;
      ST_LOAD: begin
        lane_clr = 1'b1;
        state_d  = ST_MAC;
      end
      ST_MAC: begin
        lane_en = 1'b1;
        if (last_k) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en    = 1'b1;
        lane_clr = 1'b1;
        state_d  = last_tile ? ST_DONE : ST_MAC;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tile and k indices: k sweeps within MAC, ng then m advance on WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  <= '0;
      ng_q <= '0;
      k_q  <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          m_q  <= '0;
          ng_q <= '0;
          k_q  <= '0;
        end
        ST_MAC: k_q <= last_k ? '0 : k_q + KW'(1);
        ST_WRITE: begin
          if (last_ng) begin
            ng_q <= '0;
            m_q  <= last_m ? '0 : m_q + MW'(1);
          end else begin
            ng_q <= ng_q + NGW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign a_el = a_lat[flat_idx(int'(m_q), int'(k_q), K_DIM)*DATA_WIDTH +: DATA_WIDTH];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_WIDTH-1:0]  b_el;
    logic signed [ACCUM_WIDTH-1:0] acc;
    logic signed [63:0]            c_ext;

    assign b_el = b_lat[flat_idx(int'(k_q), int'(ng_q)*LANES + l, N_DIM)*DATA_WIDTH +: DATA_WIDTH];

    matmul_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACCUM_WIDTH(ACCUM_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (lane_clr),
      .en   (lane_en),
      .a    (a_el),
      .b    (b_el),
      .acc  (acc)
    );

    assign wr_idx[l]   = CW'(flat_idx(int'(m_q), int'(ng_q)*LANES + l, N_DIM));
    assign c_new[l]    = acc_mode_q ? c_reg[wr_idx[l]] + acc : acc;
    assign c_ext       = 64'(c_new[l]);
    assign q_new[l]    = OUT_WIDTH'(sat_shift(c_ext, int'(shift_q), OUT_WIDTH));
    assign lane_sat[l] = sat_hit(c_ext, int'(shift_q), OUT_WIDTH);
  end

  // Operand latch on start, and C/q/overflow commit on WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat      <= '0;
      b_lat      <= '0;
      acc_mode_q <= 1'b0;
      shift_q    <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < M_DIM*N_DIM; i++) begin
        c_reg[i] <= '0;
        q_reg[i] <= '0;
      end
    end else if (state_q == ST_IDLE && bus.op_start_mm) begin
      a_lat      <= bus.matrix_a_flat;
      b_lat      <= bus.matrix_b_flat;
      acc_mode_q <= bus.acc_mode;
      shift_q    <= bus.shift_amt;
      ovf_q      <= 1'b0;
    end else if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        c_reg[wr_idx[l]] <= c_new[l];
        q_reg[wr_idx[l]] <= q_new[l];
      end
      ovf_q <= ovf_q | (|lane_sat);
    end
  end

  for (genvar i = 0; i < M_DIM*N_DIM; i++) begin : g_out
    assign bus.output_matrix_c_flat[i*ACCUM_WIDTH +: ACCUM_WIDTH] = c_reg[i];
    assign bus.output_q_flat[i*OUT_WIDTH +: OUT_WIDTH]            = q_reg[i];
  end

  assign bus.op_busy_mm    = (state_q == ST_LOAD) || (state_q == ST_MAC) || (state_q == ST_WRITE);
  assign bus.op_done_mm    = (state_q == ST_DONE);
  assign bus.overflow_flag = ovf_q;

endmodule

// File: tb/tb_matmul_tiled_engine.sv
// Bench for matmul_tiled_engine: directed and random operations on a 1-lane and a 2-lane instance.
module tb_matmul_tiled_engine;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int M  = 2;
  localparam int K  = 3;
  localparam int N  = 2;
  localparam int SW = 5;

  logic clk_tb = 1'b0;
  logic rst_n;

  always #5 clk_tb = ~clk_tb;

  matmul_tiled_engine_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW),
    .M_DIM(M), .K_DIM(K), .N_DIM(N), .SHIFT_W(SW)) bus1 ();
  matmul_tiled_engine_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW),
    .M_DIM(M), .K_DIM(K), .N_DIM(N), .SHIFT_W(SW)) bus2 ();

  matmul_tiled_engine #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW),
    .M_DIM(M), .K_DIM(K), .N_DIM(N), .LANES(1), .SHIFT_W(SW)) dut1 (
    .clk(clk_tb), .rst_n(rst_n), .bus(bus1));

  matmul_tiled_engine #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW),
    .M_DIM(M), .K_DIM(K), .N_DIM(N), .LANES(2), .SHIFT_W(SW)) dut2 (
    .clk(clk_tb), .rst_n(rst_n), .bus(bus2));

  int n_assert = 0;
  int n_fail   = 0;

  int a_m [M*K];
  int b_m [K*N];

  // Reference state, index 1 = dut1, 2 = dut2.
  logic [AW-1:0] c_exp   [1:2][M*N];
  logic [OW-1:0] q_exp   [1:2][M*N];
  logic          ovf_exp [1:2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M*K*DW-1:0] pack_a();
    logic [M*K*DW-1:0] r;
    int v;
    for (int i = 0; i < M*K; i++) begin
      v = a_m[i];
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [K*N*DW-1:0] pack_b();
    logic [K*N*DW-1:0] r;
    int v;
    for (int i = 0; i < K*N; i++) begin
      v = b_m[i];
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] c_obs(input int which, input int i);
    return (which == 1) ? bus1.output_matrix_c_flat[i*AW +: AW] : bus2.output_matrix_c_flat[i*AW +: AW];
  endfunction

  function automatic logic [OW-1:0] q_obs(input int which, input int i);
    return (which == 1) ? bus1.output_q_flat[i*OW +: OW] : bus2.output_q_flat[i*OW +: OW];
  endfunction

  function automatic logic busy_obs(input int which);
    return (which == 1) ? bus1.op_busy_mm : bus2.op_busy_mm;
  endfunction

  function automatic logic done_obs(input int which);
    return (which == 1) ? bus1.op_done_mm : bus2.op_done_mm;
  endfunction

  function automatic logic ovf_obs(input int which);
    return (which == 1) ? bus1.overflow_flag : bus2.overflow_flag;
  endfunction

  task automatic drive(input int which, input logic start, input logic acc, input logic [SW-1:0] sh,
                       input logic [M*K*DW-1:0] af, input logic [K*N*DW-1:0] bf);
    if (which == 1) begin
      bus1.op_start_mm = start; bus1.acc_mode = acc; bus1.shift_amt = sh;
      bus1.matrix_a_flat = af;  bus1.matrix_b_flat = bf;
    end else begin
      bus2.op_start_mm = start; bus2.acc_mode = acc; bus2.shift_amt = sh;
      bus2.matrix_a_flat = af;  bus2.matrix_b_flat = bf;
    end
  endtask

  // Matrix product from the element arrays, then the shift/clip rule.
  task automatic model_op(input int which, input bit acc, input int sh);
    longint hi, lo, v, s;
    logic signed [AW-1:0] cn;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    ovf_exp[which] = 1'b0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        s = 0;
        for (int k = 0; k < K; k++) s += longint'(a_m[m*K+k]) * longint'(b_m[k*N+n]);
        cn = acc ? $signed(c_exp[which][m*N+n]) + AW'(s) : AW'(s);
        v = longint'(cn) >>> sh;
        if (v > hi)      begin v = hi; ovf_exp[which] = 1'b1; end
        else if (v < lo) begin v = lo; ovf_exp[which] = 1'b1; end
        c_exp[which][m*N+n] = cn;
        q_exp[which][m*N+n] = v[OW-1:0];
      end
    end
  endtask

  task automatic clear_model();
    for (int w = 1; w <= 2; w++) begin
      for (int i = 0; i < M*N; i++) begin
        c_exp[w][i] = '0;
        q_exp[w][i] = '0;
      end
      ovf_exp[w] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int which, input string tag);
    for (int i = 0; i < M*N; i++) begin
      chk($sformatf("%s_c%0d", tag, i), 64'(c_obs(which, i)), 64'(c_exp[which][i]));
      chk($sformatf("%s_q%0d", tag, i), 64'(q_obs(which, i)), 64'(q_exp[which][i]));
    end
    chk({tag, "_ovf"}, 64'(ovf_obs(which)), 64'(ovf_exp[which]));
  endtask

  task automatic set_test1();
    a_m = '{1, 2, 3, 4, 5, 6};
    b_m = '{7, 8, 9, 1, 2, 3};
  endtask

  task automatic set_random();
    for (int i = 0; i < M*K; i++) a_m[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < K*N; i++) b_m[i] = int'($urandom_range(255)) - 128;
  endtask

  // One operation: start pulse, bounded wait for done, latency/busy/pulse checks, result checks.
  task automatic run_op(input int which, input bit acc, input int sh, input int exp_lat,
                        input bit perturb, input bit restart, input string tag);
    int lat, busy_cnt, extra_done;
    bit got_done;
    logic [M*K*DW-1:0] af;
    logic [K*N*DW-1:0] bf;
    af = pack_a();
    bf = pack_b();
    model_op(which, acc, sh);
    @(posedge clk_tb); #1;
    drive(which, 1'b1, acc, SW'(sh), af, bf);
    @(posedge clk_tb); #1;
    if (perturb) drive(which, 1'b0, ~acc, SW'(sh + 3), ~af, {bf[K*N*DW-2:0], ~bf[K*N*DW-1]});
    else         drive(which, 1'b0, acc, SW'(sh), af, bf);
    busy_cnt = busy_obs(which) ? 1 : 0;
    lat = 0;
    got_done = 1'b0;
    while (!got_done && lat < 200) begin
      @(posedge clk_tb); #1;
      lat++;
      if (restart && lat == 3)
        drive(which, 1'b1, acc, SW'(sh), af, bf);
      else if (restart && lat == 4)
        drive(which, 1'b0, acc, SW'(sh), af, bf);
      if (done_obs(which)) got_done = 1'b1;
      else if (busy_obs(which)) busy_cnt++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, "_busy_in_done"}, 64'(busy_obs(which)), 64'd0);
    extra_done = 0;
    repeat (exp_lat + 4) begin
      @(posedge clk_tb); #1;
      if (done_obs(which)) extra_done++;
    end
    chk({tag, "_extra_done"}, 64'(extra_done), 64'd0);
    check_outputs(which, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0, '0);
    clear_model();
    #12;
    check_outputs(1, "reset1");
    check_outputs(2, "reset2");
    chk("reset_busy", 64'(busy_obs(1)), 64'd0);
    chk("reset_done", 64'(done_obs(1)), 64'd0);
    @(negedge clk_tb);
    rst_n = 1'b1;

    set_test1();
    run_op(1, 1'b0, 0, 17, 1'b0, 1'b0, "t1");
    chk("t1_c00_const", 64'(c_obs(1, 0)), 64'd31);
    chk("t1_c11_const", 64'(c_obs(1, 3)), 64'd55);
    chk("t1_q10_const", 64'(q_obs(1, 2)), 64'd85);

    run_op(1, 1'b1, 0, 17, 1'b0, 1'b0, "t2acc");
    chk("t2_c01_const", 64'(c_obs(1, 1)), 64'd38);
    chk("t2_c10_const", 64'(c_obs(1, 2)), 64'd170);

    for (int i = 0; i < M*K; i++) a_m[i] = -128;
    for (int i = 0; i < K*N; i++) b_m[i] = -128;
    run_op(1, 1'b0, 0, 17, 1'b0, 1'b0, "t3sat");
    chk("t3_c_const", 64'(c_obs(1, 3)), 64'd49152);
    chk("t3_q_const", 64'(q_obs(1, 3)), 64'd32767);
    chk("t3_ovf_const", 64'(ovf_obs(1)), 64'd1);
    run_op(1, 1'b0, 2, 17, 1'b0, 1'b0, "t3shift");
    chk("t3s_q_const", 64'(q_obs(1, 0)), 64'd12288);
    chk("t3s_ovf_const", 64'(ovf_obs(1)), 64'd0);

    set_test1();
    run_op(2, 1'b0, 0, 9, 1'b0, 1'b0, "t4lanes2");
    chk("t4_c10_const", 64'(c_obs(2, 2)), 64'd85);

    run_op(1, 1'b0, 0, 17, 1'b1, 1'b1, "t5restart");

    // Reset during the second tile's MAC phase.
    begin
      int lat;
      bit early_done;
      set_random();
      @(posedge clk_tb); #1;
      drive(1, 1'b1, 1'b1, SW'(1), pack_a(), pack_b());
      @(posedge clk_tb); #1;
      drive(1, 1'b0, 1'b1, SW'(1), pack_a(), pack_b());
      lat = 0;
      early_done = 1'b0;
      while (lat < 6) begin
        @(posedge clk_tb); #1;
        lat++;
        if (done_obs(1)) early_done = 1'b1;
      end
      chk("t6_busy_before_reset", 64'(busy_obs(1)), 64'd1);
      chk("t6_no_early_done", 64'(early_done), 64'd0);
      rst_n = 1'b0;
      #1;
      clear_model();
      check_outputs(1, "t6rst1");
      check_outputs(2, "t6rst2");
      chk("t6_busy", 64'(busy_obs(1)), 64'd0);
      repeat (3) begin
        @(posedge clk_tb); #1;
        chk("t6_done_in_reset", 64'(done_obs(1)), 64'd0);
      end
      rst_n = 1'b1;
      repeat (20) begin
        @(posedge clk_tb); #1;
        chk("t6_done_after_abort", 64'(done_obs(1)), 64'd0);
      end
    end

    set_test1();
    run_op(1, 1'b0, 0, 17, 1'b0, 1'b0, "t6post");

    for (int r = 0; r < 6; r++) begin
      set_random();
      run_op(1, 1'(($urandom_range(1))), int'($urandom_range(14)), 17, 1'b0, 1'b0,
             $sformatf("rnd1_%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      set_random();
      run_op(2, 1'(($urandom_range(1))), int'($urandom_range(14)), 9, 1'b0, 1'b0,
             $sformatf("rnd2_%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_tiled_engine.md
Name: matmul_tiled_engine

Overview:
- Parametrised successor to the single-lane generic matrix multiply unit: computes C = A*B, or C += A*B, for an MxK by KxN signed matrix pair.
- LANES parallel MAC lanes each compute one output column per tile.
- Adds an accumulate mode for K-tiling across operations, and a requantised output path with saturation (arithmetic right shift plus clip to OUT_WIDTH).
- Sits in the transformer datapath under the attention/FFN controllers; flattened vector ports replace array ports.

Parameters:
- DATA_WIDTH, 8, signed element width of A and B.
- ACCUM_WIDTH, 32, accumulator and raw C element width.
- OUT_WIDTH, 16, requantised C element width.
- M_DIM, 2, rows of A and C.
- K_DIM, 3, columns of A and rows of B.
- N_DIM, 2, columns of B and C.
- LANES, 1, parallel MAC lanes; N_DIM % LANES must be 0, otherwise elaboration error.
- SHIFT_W, 5, width of shift_amt.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- op_start_mm, input, 1, start pulse; sampled only in IDLE.
- acc_mode, input, 1, 0 = overwrite C, 1 = C += A*B; latched at start.
- shift_amt, input, SHIFT_W, arithmetic right shift applied before saturation; latched at start.
- matrix_a_flat, input, M_DIM*K_DIM*DATA_WIDTH, element [m][k] at bit offset (m*K_DIM+k)*DATA_WIDTH.
- matrix_b_flat, input, K_DIM*N_DIM*DATA_WIDTH, element [k][n] at offset (k*N_DIM+n)*DATA_WIDTH.
- output_matrix_c_flat, output, M_DIM*N_DIM*ACCUM_WIDTH, raw C, row-major.
- output_q_flat, output, M_DIM*N_DIM*OUT_WIDTH, saturated (C >>> shift), row-major.
- op_busy_mm, output, 1, high while an operation is in flight.
- op_done_mm, output, 1, one-cycle completion pulse.
- overflow_flag, output, 1, sticky per operation; set if any q element saturated.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; all outputs, C registers, lane accumulators and latched operands to 0.
- Reset mid-operation aborts the operation; no done pulse is issued.
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE: op_start_mm=1 at an edge latches A, B, acc_mode and shift_amt, clears overflow_flag, and enters LOAD. Inputs may change afterwards without effect.
- LOAD (1 cycle): clear lane accumulators; set tile indices m=0, ng=0; enter MAC.
- MAC (K_DIM cycles): lane l accumulates A[m][k]*B[k][ng*LANES+l] for k=0..K_DIM-1; after k=K_DIM-1, enter WRITE.
- WRITE (1 cycle):
  - Store each lane result to C[m][ng*LANES+l]; if acc_mode=1, store C_old + lane result instead.
  - Update the matching q element and OR its saturation into overflow_flag.
  - Clear accumulators; advance ng, then m.
  - If the tile was the last one, enter DONE; otherwise enter MAC.
- DONE (1 cycle): op_done_mm=1, op_busy_mm=0; return to IDLE.
- op_busy_mm = 1 in LOAD, MAC and WRITE.
- Latency: tiles T = M_DIM*N_DIM/LANES. op_done_mm is high in the cycle after edge 1+T*(K_DIM+1), counted from the start-sampling edge 0. Busy lasts 1+T*(K_DIM+1) cycles.
- Arithmetic:
  - Products are full 2*DATA_WIDTH signed, sign-extended to ACCUM_WIDTH.
  - Accumulation and acc_mode addition wrap two's-complement at ACCUM_WIDTH; no saturation in C.
  - q = clip(C >>> shift_amt, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
- op_start_mm while busy or in DONE is ignored.
- Output registers change only in WRITE; they hold stable from done until the next operation's first WRITE.

Decomposition:
- Package matmul_pkg:
  - state enum;
  - clog2-based index-width constants;
  - saturate-shift function (ACCUM_WIDTH to OUT_WIDTH);
  - flat-index helper functions.
- Sub-module matmul_mac_lane: one signed MAC with clear and enable, and an ACCUM_WIDTH accumulator; instantiated LANES times via generate.

Test Plan:
- Defaults, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,1],[2,3]], acc_mode=0, shift=0 -> C=q=[[31,19],[85,55]]; done exactly 17 edges after start; busy 17 cycles; overflow_flag=0.
- Repeat test 1 with acc_mode=1 -> C=[[62,38],[170,110]]; done again at 17 edges.
- All A and B elements = -128, shift=0 -> every C=49152, q=32767, overflow_flag=1. Rerun with shift=2 -> q=12288, overflow_flag=0 (cleared at start).
- Instance with LANES=2, test 1 data -> same C; done 9 edges after start.
- Second start pulse while busy -> ignored, single done pulse. Change A/B one cycle after start -> result unchanged.
- Assert rst_n=0 during MAC of tile 2 -> all outputs 0 immediately, no done pulse. After release, test 1 passes.
